// File: rtl/occ_read_arbiter_pkg.sv
// Shared definitions for the Occ read arbiter: FSM state encodings and
// the lane-index width helper used by the top level and the round-robin picker.
package occ_read_arbiter_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ISSUE_LO = 3'd1;
   localparam logic [2:0] ST_ISSUE_HI = 3'd2;
   localparam logic [2:0] ST_WAIT     = 3'd3;
   localparam logic [2:0] ST_RESP     = 3'd4;

   // Lane index width; a single lane still needs a 1-bit index.
   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/occ_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after
// i_rr_ptr, wrapping modulo N. Produces a one-hot grant and its index.
module occ_read_arbiter_rr_pick
   import occ_read_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int LW = lane_w(N)
)(
   input  logic [N-1:0]  i_req,
   input  logic [LW-1:0] i_rr_ptr,
   output logic [N-1:0]  o_grant,
   output logic [LW-1:0] o_winner,
   output logic          o_any
);

   logic [LW:0]   w_pos;
   logic [LW-1:0] w_idx;

   always_comb begin
      o_grant  = '0;
      o_winner = '0;
      o_any    = 1'b0;
      w_pos    = '0;
      w_idx    = '0;
      // Walk from the farthest offset back to rr_ptr so the closest hit wins last.
      for (int k = N - 1; k >= 0; k--) begin
         w_pos = {1'b0, i_rr_ptr} + (LW+1)'(k);
         if (w_pos >= (LW+1)'(N))
            w_pos = w_pos - (LW+1)'(N);
         w_idx = w_pos[LW-1:0];
         if (i_req[w_idx]) begin
            o_grant        = '0;
            o_grant[w_idx] = 1'b1;
            o_winner       = w_idx;
            o_any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/occ_read_arbiter.sv
// Shares one Occ memory read port among N lanes: grants a lane round-robin,
// issues its lo/hi reads back-to-back and returns both words with a valid pulse.
module occ_read_arbiter
   import occ_read_arbiter_pkg::*;
#(
   parameter int N      = 4,
   parameter int AW     = 16,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*AW-1:0] addr_lo,
   input  logic [N*AW-1:0] addr_hi,
   output logic [N-1:0]    ack,
   output logic [N-1:0]    rsp_valid,
   output logic [DW-1:0]   rsp_lo,
   output logic [DW-1:0]   rsp_hi,
   output logic            busy,
   output logic            mem_en,
   output logic [AW-1:0]   mem_addr,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int LW = lane_w(N);
   localparam int CW = $clog2(RD_LAT + 2);
   // Counter is RD_LAT+1 in the ISSUE_LO cycle: lo data lands at 1, hi data at 0.
   localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT + 1);

   logic [2:0]    r_state;
   logic [LW-1:0] r_rr_ptr;
   logic [LW-1:0] r_win;
   logic [N-1:0]  r_grant;
   logic [AW-1:0] r_hi_addr;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_ack;
   logic [N-1:0]  r_rsp_valid;
   logic [DW-1:0] r_rsp_lo;
   logic [DW-1:0] r_rsp_hi;
   logic          r_mem_en;
   logic [AW-1:0] r_mem_addr;

   logic [AW-1:0] w_lo_arr [N];
   logic [AW-1:0] w_hi_arr [N];
   logic [N-1:0]  w_grant;
   logic [LW-1:0] w_winner;
   logic          w_any;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign w_lo_arr[gi] = addr_lo[gi*AW +: AW];
         assign w_hi_arr[gi] = addr_hi[gi*AW +: AW];
      end
   endgenerate

   occ_read_arbiter_rr_pick #(
      .N  (N),
      .LW (LW)
   ) u_pick (
      .i_req    (req),
      .i_rr_ptr (r_rr_ptr),
      .o_grant  (w_grant),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_win       <= '0;
         r_grant     <= '0;
         r_hi_addr   <= '0;
         r_cnt       <= '0;
         r_ack       <= '0;
         r_rsp_valid <= '0;
         r_rsp_lo    <= '0;
         r_rsp_hi    <= '0;
         r_mem_en    <= 1'b0;
         r_mem_addr  <= '0;
      end else begin
         r_ack       <= '0;
         r_rsp_valid <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_win      <= w_winner;
                  r_grant    <= w_grant;
                  r_hi_addr  <= w_hi_arr[w_winner];
                  r_ack      <= w_grant;
                  r_mem_en   <= 1'b1;
                  r_mem_addr <= w_lo_arr[w_winner];
                  r_cnt      <= CNT_LOAD;
                  r_state    <= ST_ISSUE_LO;
               end
            end
            ST_ISSUE_LO: begin
               r_mem_addr <= r_hi_addr;
               r_cnt      <= r_cnt - 1'b1;
               r_state    <= ST_ISSUE_HI;
            end
            ST_ISSUE_HI, ST_WAIT: begin
               r_mem_en <= 1'b0;
               r_cnt    <= r_cnt - 1'b1;
               if (r_cnt == CW'(1))
                  r_rsp_lo <= mem_rdata;
               if (r_cnt == '0) begin
                  r_rsp_hi    <= mem_rdata;
                  r_rsp_valid <= r_grant;
                  r_state     <= ST_RESP;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_RESP: begin
               r_rr_ptr <= (r_win == LW'(N - 1)) ? '0 : r_win + 1'b1;
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ack       = r_ack;
   assign rsp_valid = r_rsp_valid;
   assign rsp_lo    = r_rsp_lo;
   assign rsp_hi    = r_rsp_hi;
   assign busy      = (r_state != ST_IDLE);
   assign mem_en    = r_mem_en;
   assign mem_addr  = r_mem_addr;

endmodule
